// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// An internal frame timer spaces i_Tx_Ready pulses exactly one frame apart.
module uart_tx_arbiter #(
   parameter int unsigned CLOCK_RATE = 100_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_BITS   = 1,
   localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_enable,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_byte,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [7:0]           o_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic [ID_W-1:0]      o_grant_id,
   output logic                 o_busy,
   output logic [15:0]          o_frame_count
);

   localparam int unsigned BIT_CYCLES   = CLOCK_RATE / BAUD_RATE;
   localparam int unsigned FRAME_CYCLES = BIT_CYCLES * (10 + GAP_BITS);
   localparam int unsigned TMR_W        = $clog2(FRAME_CYCLES);
   localparam int unsigned CNT_W        = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_SEND  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t               r_state;
   logic [ID_W-1:0]      r_ptr;
   logic [TMR_W-1:0]     r_timer;
   logic [NUM_REQ-1:0]   r_req_ready;
   logic [7:0]           r_tx_byte;
   logic                 r_tx_ready;
   logic [ID_W-1:0]      r_grant_id;
   logic                 r_busy;
   logic [CNT_W-1:0]     r_frame_count;

   state_t               w_state_nxt;
   logic [ID_W-1:0]      w_ptr_nxt;
   logic [TMR_W-1:0]     w_timer_nxt;
   logic [NUM_REQ-1:0]   w_req_ready_nxt;
   logic [7:0]           w_tx_byte_nxt;
   logic                 w_tx_ready_nxt;
   logic [ID_W-1:0]      w_grant_id_nxt;
   logic                 w_busy_nxt;
   logic [CNT_W-1:0]     w_frame_count_nxt;

   logic [31:0]          w_ptr32;
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [2*NUM_REQ-1:0] w_dbl_oh;
   logic [NUM_REQ-1:0]   w_sel_oh;
   logic                 w_found;
   logic [ID_W-1:0]      w_sel;
   logic [7:0]           w_sel_byte;

   // Round-robin pick: first valid index after r_ptr on a doubled request vector
   always_comb begin : arb_pick
      w_ptr32    = 32'(r_ptr);
      w_dbl      = {i_req_valid, i_req_valid};
      w_dbl_oh   = '0;
      w_found    = 1'b0;
      w_sel      = '0;
      w_sel_byte = '0;
      for (int unsigned j = 0; j < 2*NUM_REQ; j++) begin
         if (!w_found && w_dbl[j] && (j > w_ptr32) && (j <= w_ptr32 + NUM_REQ)) begin
            w_found     = 1'b1;
            w_dbl_oh[j] = 1'b1;
         end
      end
      w_sel_oh = w_dbl_oh[NUM_REQ-1:0] | w_dbl_oh[2*NUM_REQ-1:NUM_REQ];
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_sel_oh[k]) begin
            w_sel      = ID_W'(k);
            w_sel_byte = i_req_byte[8*k +: 8];
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin : fsm_next
      w_state_nxt       = r_state;
      w_ptr_nxt         = r_ptr;
      w_timer_nxt       = r_timer;
      w_req_ready_nxt   = '0;
      w_tx_byte_nxt     = r_tx_byte;
      w_tx_ready_nxt    = 1'b0;
      w_grant_id_nxt    = r_grant_id;
      w_busy_nxt        = r_busy;
      w_frame_count_nxt = r_frame_count;
      case (r_state)
         S_IDLE: begin
            if (i_enable && w_found) begin
               w_state_nxt     = S_GRANT;
               w_req_ready_nxt = w_sel_oh;
               w_tx_byte_nxt   = w_sel_byte;
               w_grant_id_nxt  = w_sel;
               w_ptr_nxt       = w_sel;
               w_busy_nxt      = 1'b1;
            end
         end
         S_GRANT: begin
            w_state_nxt       = S_SEND;
            w_tx_ready_nxt    = 1'b1;
            w_frame_count_nxt = r_frame_count + CNT_W'(1);
         end
         S_SEND: begin
            // GRANT + SEND + IDLE + (FRAME_CYCLES-3) WAIT cycles = one frame
            w_state_nxt = S_WAIT;
            w_timer_nxt = TMR_W'(FRAME_CYCLES - 4);
         end
         S_WAIT: begin
            if (r_timer == '0) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin : fsm_reg
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_ptr         <= ID_W'(NUM_REQ - 1);
         r_timer       <= '0;
         r_req_ready   <= '0;
         r_tx_byte     <= '0;
         r_tx_ready    <= 1'b0;
         r_grant_id    <= '0;
         r_busy        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_timer       <= w_timer_nxt;
         r_req_ready   <= w_req_ready_nxt;
         r_tx_byte     <= w_tx_byte_nxt;
         r_tx_ready    <= w_tx_ready_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_busy        <= w_busy_nxt;
         r_frame_count <= w_frame_count_nxt;
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_Tx_Byte     = r_tx_byte;
   assign o_Tx_Ready    = r_tx_ready;
   assign o_grant_id    = r_grant_id;
   assign o_busy        = r_busy;
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 110-cycle frame
// (CLOCK_RATE=1000, BAUD_RATE=100, GAP_BITS=1).
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned FRAME = 110;

   logic        clk;
   logic        reset_n;
   logic        i_enable;
   logic [3:0]  i_req_valid;
   logic [31:0] i_req_byte;
   logic [3:0]  o_req_ready;
   logic [7:0]  o_Tx_Byte;
   logic        o_Tx_Ready;
   logic [1:0]  o_grant_id;
   logic        o_busy;
   logic [15:0] o_frame_count;

   int n_vec;
   int n_err;

   // capture of Tx pulses seen by collect()
   int          n_got;
   int          p_cyc  [16];
   logic [7:0]  p_byte [16];
   logic [1:0]  p_id   [16];
   logic [15:0] p_cnt  [16];
   logic [3:0]  seen_ready;
   int          viol;

   uart_tx_arbiter #(
      .CLOCK_RATE(1000),
      .BAUD_RATE (100),
      .NUM_REQ   (NREQ),
      .GAP_BITS  (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_enable     (i_enable),
      .i_req_valid  (i_req_valid),
      .i_req_byte   (i_req_byte),
      .o_req_ready  (o_req_ready),
      .o_Tx_Byte    (o_Tx_Byte),
      .o_Tx_Ready   (o_Tx_Ready),
      .o_grant_id   (o_grant_id),
      .o_busy       (o_busy),
      .o_frame_count(o_frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records up to n_want Tx pulses plus ready/adjacency violations.
   task automatic collect(input int n_want, input int budget);
      logic prev_tx;
      n_got      = 0;
      seen_ready = '0;
      viol       = 0;
      prev_tx    = 1'b0;
      for (int c = 0; c < budget && n_got < n_want; c++) begin
         tick();
         if ((o_req_ready & (o_req_ready - 4'd1)) != 4'd0) viol++;
         seen_ready = seen_ready | o_req_ready;
         if (o_Tx_Ready) begin
            if (prev_tx) viol++;
            if (n_got < 16) begin
               p_cyc[n_got]  = c;
               p_byte[n_got] = o_Tx_Byte;
               p_id[n_got]   = o_grant_id;
               p_cnt[n_got]  = o_frame_count;
            end
            n_got++;
         end
         prev_tx = o_Tx_Ready;
      end
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (o_busy && c < budget) begin
         tick();
         c++;
      end
      if (o_busy) begin
         n_vec++; n_err++;
         $display("FAIL wait_idle: o_busy still %0b after %0d cycles, required 0", o_busy, budget);
      end
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      i_enable    = 1'b0;
      i_req_valid = '0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      i_enable    = 1'b0;
      i_req_valid = '0;
      i_req_byte  = 32'h4433_2211;
      tick(); tick(); tick();
      n_vec++; if (o_req_ready !== 4'h0)    begin n_err++; $display("FAIL rst_ready: got %h want 0", o_req_ready); end
      n_vec++; if (o_Tx_Ready !== 1'b0)     begin n_err++; $display("FAIL rst_txrdy: got %b want 0", o_Tx_Ready); end
      n_vec++; if (o_Tx_Byte !== 8'h00)     begin n_err++; $display("FAIL rst_byte: got %h want 00", o_Tx_Byte); end
      n_vec++; if (o_grant_id !== 2'd0)     begin n_err++; $display("FAIL rst_gid: got %0d want 0", o_grant_id); end
      n_vec++; if (o_busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      n_vec++; if (o_frame_count !== 16'h0) begin n_err++; $display("FAIL rst_count: got %h want 0000", o_frame_count); end
      reset_n = 1'b1;
      tick(); tick();
      n_vec++; if (o_busy !== 1'b0 || o_req_ready !== 4'h0) begin
         n_err++; $display("FAIL rst_release_idle: busy %b ready %h want 0/0", o_busy, o_req_ready);
      end
   endtask

   task automatic test_single();
      logic extra_tx;
      i_enable    = 1'b1;
      i_req_byte  = 32'h4433_22AA;
      i_req_valid = 4'b0001;
      tick();
      n_vec++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", o_req_ready); end
      n_vec++; if (o_Tx_Byte !== 8'hAA)     begin n_err++; $display("FAIL single_grant_byte: got %h want AA", o_Tx_Byte); end
      n_vec++; if (o_grant_id !== 2'd0)     begin n_err++; $display("FAIL single_gid: got %0d want 0", o_grant_id); end
      n_vec++; if (o_busy !== 1'b1)         begin n_err++; $display("FAIL single_busy_grant: got %b want 1", o_busy); end
      n_vec++; if (o_Tx_Ready !== 1'b0)     begin n_err++; $display("FAIL single_txrdy_grant: got %b want 0", o_Tx_Ready); end
      i_req_valid = 4'b0000;
      tick();
      n_vec++; if (o_Tx_Ready !== 1'b1)     begin n_err++; $display("FAIL single_txrdy: got %b want 1", o_Tx_Ready); end
      n_vec++; if (o_Tx_Byte !== 8'hAA)     begin n_err++; $display("FAIL single_send_byte: got %h want AA", o_Tx_Byte); end
      n_vec++; if (o_frame_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", o_frame_count); end
      n_vec++; if (o_req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_send: got %b want 0000", o_req_ready); end
      // now at GRANT+1; advance to GRANT+108
      extra_tx = 1'b0;
      for (int i = 0; i < 107; i++) begin
         tick();
         if (o_Tx_Ready) extra_tx = 1'b1;
      end
      n_vec++; if (o_busy !== 1'b1)   begin n_err++; $display("FAIL single_busy_108: got %b want 1", o_busy); end
      n_vec++; if (extra_tx !== 1'b0) begin n_err++; $display("FAIL single_extra_tx: got %b want 0", extra_tx); end
      tick();
      n_vec++; if (o_busy !== 1'b0)   begin n_err++; $display("FAIL single_busy_109: got %b want 0", o_busy); end
      n_vec++; if (o_Tx_Byte !== 8'hAA || o_grant_id !== 2'd0) begin
         n_err++; $display("FAIL single_hold: byte %h gid %0d want AA/0", o_Tx_Byte, o_grant_id);
      end
   endtask

   task automatic test_rr_all();
      logic [7:0] exp_b [5];
      logic [1:0] exp_i [5];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44; exp_b[4] = 8'h11;
      exp_i[0] = 2'd0;  exp_i[1] = 2'd1;  exp_i[2] = 2'd2;  exp_i[3] = 2'd3;  exp_i[4] = 2'd0;
      apply_reset();
      i_enable    = 1'b1;
      i_req_byte  = 32'h4433_2211;
      i_req_valid = 4'b1111;
      collect(5, 700);
      n_vec++; if (n_got !== 5) begin n_err++; $display("FAIL rr_all_pulses: got %0d want 5", n_got); end
      for (int k = 0; k < 5 && k < n_got; k++) begin
         n_vec++; if (p_byte[k] !== exp_b[k]) begin n_err++; $display("FAIL rr_all_byte[%0d]: got %h want %h", k, p_byte[k], exp_b[k]); end
         n_vec++; if (p_id[k] !== exp_i[k])   begin n_err++; $display("FAIL rr_all_id[%0d]: got %0d want %0d", k, p_id[k], exp_i[k]); end
         n_vec++; if (p_cnt[k] !== 16'(k + 1)) begin n_err++; $display("FAIL rr_all_count[%0d]: got %0d want %0d", k, p_cnt[k], k + 1); end
         if (k > 0) begin
            n_vec++; if (p_cyc[k] - p_cyc[k-1] !== FRAME) begin
               n_err++; $display("FAIL rr_all_spacing[%0d]: got %0d want %0d", k, p_cyc[k] - p_cyc[k-1], FRAME);
            end
         end
      end
      n_vec++; if (viol !== 0) begin n_err++; $display("FAIL rr_all_protocol: got %0d violations want 0", viol); end
      i_req_valid = 4'b0000;
      wait_idle(200);
   endtask

   task automatic test_rr_pair();
      logic [1:0] exp_i [4];
      int c;
      exp_i[0] = 2'd3; exp_i[1] = 2'd1; exp_i[2] = 2'd3; exp_i[3] = 2'd1;
      // move the pointer to requester 1
      i_req_valid = 4'b0010;
      c = 0;
      while (o_req_ready !== 4'b0010 && c < 20) begin tick(); c++; end
      n_vec++; if (o_req_ready !== 4'b0010) begin n_err++; $display("FAIL pair_setup: ready %b want 0010", o_req_ready); end
      i_req_valid = 4'b0000;
      wait_idle(200);
      i_req_valid = 4'b1010;
      collect(4, 500);
      n_vec++; if (n_got !== 4) begin n_err++; $display("FAIL pair_pulses: got %0d want 4", n_got); end
      for (int k = 0; k < 4 && k < n_got; k++) begin
         n_vec++; if (p_id[k] !== exp_i[k]) begin n_err++; $display("FAIL pair_id[%0d]: got %0d want %0d", k, p_id[k], exp_i[k]); end
      end
      n_vec++; if (seen_ready !== 4'b1010) begin n_err++; $display("FAIL pair_ready_set: got %b want 1010", seen_ready); end
      n_vec++; if (p_byte[0] !== 8'h44)   begin n_err++; $display("FAIL pair_byte0: got %h want 44", p_byte[0]); end
      i_req_valid = 4'b0000;
      wait_idle(200);
   endtask

   task automatic test_enable();
      i_enable    = 1'b0;
      i_req_byte  = 32'h445C_2211;
      i_req_valid = 4'b0100;
      collect(1, 30);
      n_vec++; if (n_got !== 0)          begin n_err++; $display("FAIL en_off_tx: got %0d pulses want 0", n_got); end
      n_vec++; if (seen_ready !== 4'h0)  begin n_err++; $display("FAIL en_off_ready: got %b want 0000", seen_ready); end
      i_enable = 1'b1;
      tick();
      n_vec++; if (o_req_ready !== 4'b0100) begin n_err++; $display("FAIL en_on_ready: got %b want 0100", o_req_ready); end
      n_vec++; if (o_grant_id !== 2'd2)     begin n_err++; $display("FAIL en_on_gid: got %0d want 2", o_grant_id); end
      i_req_valid = 4'b0000;
      tick();
      n_vec++; if (o_Tx_Ready !== 1'b1 || o_Tx_Byte !== 8'h5C) begin
         n_err++; $display("FAIL en_on_send: txrdy %b byte %h want 1/5C", o_Tx_Ready, o_Tx_Byte);
      end
      for (int i = 0; i < 10; i++) tick();
      i_enable    = 1'b0;
      i_req_valid = 4'b0001;
      collect(1, 250);
      n_vec++; if (n_got !== 0)         begin n_err++; $display("FAIL en_drop_tx: got %0d pulses want 0", n_got); end
      n_vec++; if (seen_ready !== 4'h0) begin n_err++; $display("FAIL en_drop_ready: got %b want 0000", seen_ready); end
      n_vec++; if (o_busy !== 1'b0)     begin n_err++; $display("FAIL en_drop_finish: busy %b want 0", o_busy); end
      i_req_valid = 4'b0000;
   endtask

   task automatic test_reset_mid();
      i_enable    = 1'b1;
      i_req_valid = 4'b0100;
      collect(1, 20);
      n_vec++; if (n_got !== 1) begin n_err++; $display("FAIL mid_setup: got %0d pulses want 1", n_got); end
      i_req_valid = 4'b0000;
      for (int i = 0; i < 20; i++) tick();
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mid_in_wait: busy %b want 1", o_busy); end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_vec++; if (o_Tx_Byte !== 8'h00 || o_grant_id !== 2'd0 || o_frame_count !== 16'h0) begin
         n_err++; $display("FAIL mid_rst_regs: byte %h gid %0d cnt %h want 00/0/0000", o_Tx_Byte, o_grant_id, o_frame_count);
      end
      n_vec++; if (o_busy !== 1'b0 || o_Tx_Ready !== 1'b0 || o_req_ready !== 4'h0) begin
         n_err++; $display("FAIL mid_rst_ctl: busy %b txrdy %b ready %b want 0/0/0", o_busy, o_Tx_Ready, o_req_ready);
      end
      tick(); tick();
      reset_n     = 1'b1;
      i_req_byte  = 32'h4433_2211;
      i_req_valid = 4'b1111;
      collect(1, 20);
      n_vec++; if (n_got !== 1)       begin n_err++; $display("FAIL mid_after_pulse: got %0d want 1", n_got); end
      n_vec++; if (p_id[0] !== 2'd0)  begin n_err++; $display("FAIL mid_after_id: got %0d want 0", p_id[0]); end
      n_vec++; if (p_byte[0] !== 8'h11 || p_cnt[0] !== 16'd1) begin
         n_err++; $display("FAIL mid_after_data: byte %h cnt %0d want 11/1", p_byte[0], p_cnt[0]);
      end
      i_req_valid = 4'b0000;
      wait_idle(200);
   endtask

   task automatic test_wrap();
      tick();
      force dut.r_frame_count = 16'hFFFF;
      tick();
      release dut.r_frame_count;
      i_req_valid = 4'b0001;
      collect(1, 20);
      i_req_valid = 4'b0000;
      n_vec++; if (n_got !== 1)           begin n_err++; $display("FAIL wrap_pulse: got %0d want 1", n_got); end
      n_vec++; if (p_cnt[0] !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h want 0000", p_cnt[0]); end
      wait_idle(200);
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      reset_n     = 1'b0;
      i_enable    = 1'b0;
      i_req_valid = '0;
      i_req_byte  = '0;
      test_reset();
      test_single();
      test_rr_all();
      test_rr_pair();
      test_enable();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
